// File: rtl/phys_free_list.sv
// Circular free list of physical register tags for rename. Keeps speculative and
// committed head pointers so a flush can hand back every uncommitted allocation.
module phys_free_list #(
  parameter int NREGS = 64,
  parameter int NARCH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic                                 alloc_req,
  output logic                                 alloc_valid,
  output logic [$clog2(NREGS)-1:0]             alloc_reg,
  input  logic                                 commit_alloc,
  input  logic                                 free_req,
  input  logic [$clog2(NREGS)-1:0]             free_reg,
  input  logic                                 flush,
  output logic [$clog2(NREGS-NARCH):0]         free_count,
  output logic                                 err
);

  localparam int TAG_W = $clog2(NREGS);
  localparam int DEPTH = NREGS - NARCH;
  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] fl_rd [DEPTH];

  logic [PTR_W-1:0] spec_head_reg, spec_head_next;
  logic [PTR_W-1:0] commit_head_reg, commit_head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] spec_count_reg, spec_count_next;
  logic [CNT_W-1:0] commit_count_reg, commit_count_next;
  logic             err_reg, err_next;

  logic do_alloc;
  logic do_commit;
  logic do_push;
  logic commit_bad;
  logic free_bad;

  // Ring storage; each slot resets to its initial architectural-spare tag.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fl
      logic [TAG_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_reg <= TAG_W'(NARCH + gi);
        end else if (!stall && do_push && (tail_reg == PTR_W'(gi))) begin
          slot_reg <= free_reg;
        end
      end

      assign fl_rd[gi] = slot_reg;
    end
  endgenerate

  always_comb begin
    do_alloc   = alloc_req && (spec_count_reg != '0) && !flush;
    do_commit  = commit_alloc && (commit_count_reg > spec_count_reg);
    // Fullness is judged on the committed count after this cycle's commit.
    do_push    = free_req &&
                 ((commit_count_reg - CNT_W'(do_commit)) < CNT_W'(DEPTH));
    commit_bad = commit_alloc && !do_commit;
    free_bad   = free_req && !do_push;

    commit_head_next  = commit_head_reg + PTR_W'(do_commit);
    commit_count_next = commit_count_reg - CNT_W'(do_commit) + CNT_W'(do_push);
    tail_next         = tail_reg + PTR_W'(do_push);

    if (flush) begin
      spec_head_next  = commit_head_next;
      spec_count_next = commit_count_next;
    end else begin
      spec_head_next  = spec_head_reg + PTR_W'(do_alloc);
      spec_count_next = spec_count_reg - CNT_W'(do_alloc) + CNT_W'(do_push);
    end

    err_next = err_reg | commit_bad | free_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_head_reg    <= '0;
      commit_head_reg  <= '0;
      tail_reg         <= '0;
      spec_count_reg   <= CNT_W'(DEPTH);
      commit_count_reg <= CNT_W'(DEPTH);
      err_reg          <= 1'b0;
    end else if (!stall) begin
      spec_head_reg    <= spec_head_next;
      commit_head_reg  <= commit_head_next;
      tail_reg         <= tail_next;
      spec_count_reg   <= spec_count_next;
      commit_count_reg <= commit_count_next;
      err_reg          <= err_next;
    end
  end

  assign alloc_valid = (spec_count_reg != '0);
  assign alloc_reg   = fl_rd[spec_head_reg];
  assign free_count  = spec_count_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_phys_free_list.sv
// Scenario bench for phys_free_list: expected allocation tags are queued as
// stimulus is planned and popped as the DUT presents them at alloc_reg.
module tb_phys_free_list;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_reg;
  logic       commit_alloc;
  logic       free_req;
  logic [5:0] free_reg;
  logic       flush;
  logic [5:0] free_count;
  logic       err;

  int checks;
  int failures;
  logic [5:0] exp_q[$];

  phys_free_list #(.NREGS(64), .NARCH(32)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .alloc_req(alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_reg(alloc_reg),
    .commit_alloc(commit_alloc),
    .free_req(free_req),
    .free_reg(free_reg),
    .flush(flush),
    .free_count(free_count),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then idle the inputs.
  task automatic step(input logic a, input logic c, input logic f,
                      input logic [5:0] fr, input logic fl, input logic st);
    alloc_req = a; commit_alloc = c; free_req = f; free_reg = fr;
    flush = fl; stall = st;
    @(posedge clk); #1;
    alloc_req = 1'b0; commit_alloc = 1'b0; free_req = 1'b0; free_reg = 6'd0;
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (alloc_valid !== 1'b1) begin
      failures++; $display("FAIL reset_alloc_valid got=%0b want=1", alloc_valid);
    end
    checks++;
    if (alloc_reg !== 6'd32) begin
      failures++; $display("FAIL reset_alloc_reg got=%0d want=32", alloc_reg);
    end
    checks++;
    if (free_count !== 6'd32) begin
      failures++; $display("FAIL reset_free_count got=%0d want=32", free_count);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%0b want=0", err);
    end
  endtask

  task automatic test_drain();
    logic [5:0] exp;
    apply_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
    for (int i = 0; i < 32; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (alloc_valid !== 1'b1 || alloc_reg !== exp) begin
        failures++;
        $display("FAIL drain_tag[%0d] got=%0d valid=%0b want=%0d", i, alloc_reg, alloc_valid, exp);
      end
      step(1, 0, 0, 6'd0, 0, 0);
    end
    checks++;
    if (alloc_valid !== 1'b0 || free_count !== 6'd0) begin
      failures++;
      $display("FAIL drain_empty got valid=%0b count=%0d want valid=0 count=0", alloc_valid, free_count);
    end
    step(1, 0, 0, 6'd0, 0, 0);
    checks++;
    if (alloc_valid !== 1'b0 || free_count !== 6'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL drain_extra_alloc got valid=%0b count=%0d err=%0b want 0/0/0", alloc_valid, free_count, err);
    end
  endtask

  // Continues from the drained list: retire one allocation, then free tag 5.
  task automatic test_free_no_bypass();
    step(0, 1, 0, 6'd0, 0, 0);
    free_req = 1'b1; free_reg = 6'd5;
    #1;
    checks++;
    if (alloc_valid !== 1'b0) begin
      failures++; $display("FAIL nobypass_same_cycle got valid=%0b want=0", alloc_valid);
    end
    @(posedge clk); #1;
    free_req = 1'b0; free_reg = 6'd0;
    checks++;
    if (alloc_valid !== 1'b1 || alloc_reg !== 6'd5 || free_count !== 6'd1) begin
      failures++;
      $display("FAIL nobypass_next got valid=%0b tag=%0d count=%0d want 1/5/1", alloc_valid, alloc_reg, free_count);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL nobypass_err got=%0b want=0", err);
    end
  endtask

  task automatic test_flush();
    logic [5:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(6'(32 + i));
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (alloc_reg !== exp) begin
        failures++; $display("FAIL flush_alloc[%0d] got=%0d want=%0d", i, alloc_reg, exp);
      end
      step(1, 0, 0, 6'd0, 0, 0);
    end
    step(0, 1, 0, 6'd0, 0, 0);
    step(0, 1, 0, 6'd0, 0, 0);
    step(0, 0, 0, 6'd0, 1, 0);
    checks++;
    if (free_count !== 6'd30 || alloc_reg !== 6'd34 || alloc_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_restore got count=%0d tag=%0d valid=%0b want 30/34/1", free_count, alloc_reg, alloc_valid);
    end
    step(1, 0, 0, 6'd0, 0, 0);
    checks++;
    if (alloc_reg !== 6'd35 || free_count !== 6'd29) begin
      failures++; $display("FAIL flush_next got tag=%0d count=%0d want 35/29", alloc_reg, free_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    apply_reset();
    for (int i = 0; i < 22; i++) step(1, 0, 0, 6'd0, 0, 0);
    for (int i = 0; i < 21; i++) step(0, 1, 0, 6'd0, 0, 0);
    checks++;
    if (free_count !== 6'd10 || alloc_reg !== 6'd54) begin
      failures++; $display("FAIL b2b_setup got count=%0d tag=%0d want 10/54", free_count, alloc_reg);
    end
    // Alloc of 54, push of 7 into slot 0, retire of the last outstanding tag.
    step(1, 1, 1, 6'd7, 0, 0);
    checks++;
    if (free_count !== 6'd10 || err !== 1'b0) begin
      failures++; $display("FAIL b2b_count got count=%0d err=%0b want 10/0", free_count, err);
    end
    for (int i = 0; i < 9; i++) exp_q.push_back(6'(55 + i));
    exp_q.push_back(6'd7);
    for (int i = 0; i < 10; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (alloc_valid !== 1'b1 || alloc_reg !== exp) begin
        failures++;
        $display("FAIL b2b_tag[%0d] got=%0d valid=%0b want=%0d", i, alloc_reg, alloc_valid, exp);
      end
      step(1, 0, 0, 6'd0, 0, 0);
    end
    checks++;
    if (alloc_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_empty got valid=%0b want=0", alloc_valid);
    end
    // Committed count stayed at 11 through the combined cycle.
    step(0, 0, 0, 6'd0, 1, 0);
    checks++;
    if (free_count !== 6'd11) begin
      failures++; $display("FAIL b2b_commit_count got=%0d want=11", free_count);
    end
  endtask

  task automatic test_errors();
    logic [5:0] exp;
    apply_reset();
    step(0, 1, 0, 6'd0, 0, 0);
    checks++;
    if (err !== 1'b1 || free_count !== 6'd32 || alloc_reg !== 6'd32) begin
      failures++;
      $display("FAIL err_commit got err=%0b count=%0d tag=%0d want 1/32/32", err, free_count, alloc_reg);
    end
    apply_reset();
    step(0, 0, 1, 6'd9, 0, 0);
    checks++;
    if (err !== 1'b1 || free_count !== 6'd32) begin
      failures++; $display("FAIL err_full_free got err=%0b count=%0d want 1/32", err, free_count);
    end
    // Tag 9 was dropped, so the next accepted free lands in slot 0.
    step(1, 0, 0, 6'd0, 0, 0);
    step(0, 1, 1, 6'd11, 0, 0);
    for (int i = 0; i < 31; i++) exp_q.push_back(6'(33 + i));
    exp_q.push_back(6'd11);
    for (int i = 0; i < 32; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (alloc_reg !== exp) begin
        failures++; $display("FAIL err_tail[%0d] got=%0d want=%0d", i, alloc_reg, exp);
      end
      step(1, 0, 0, 6'd0, 0, 0);
    end
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%0b want=1", err);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step(1, 0, 0, 6'd0, 0, 0);
    step(1, 0, 0, 6'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 6'd3, 1, 1);
      checks++;
      if (alloc_reg !== 6'd34 || free_count !== 6'd30 || alloc_valid !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got tag=%0d count=%0d valid=%0b err=%0b want 34/30/1/0",
                 i, alloc_reg, free_count, alloc_valid, err);
      end
    end
    alloc_req = 1'b1; free_req = 1'b1; free_reg = 6'd3; flush = 1'b1; stall = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (alloc_reg !== 6'd32 || free_count !== 6'd32 || err !== 1'b0 || alloc_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_async_reset got tag=%0d count=%0d err=%0b valid=%0b want 32/32/0/1",
               alloc_reg, free_count, err, alloc_valid);
    end
    @(posedge clk); #1;
    alloc_req = 1'b0; free_req = 1'b0; free_reg = 6'd0; flush = 1'b0; stall = 1'b0;
    reset = 1'b1;
    checks++;
    if (alloc_reg !== 6'd32 || free_count !== 6'd32) begin
      failures++; $display("FAIL stall_post_reset got tag=%0d count=%0d want 32/32", alloc_reg, free_count);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; stall = 1'b0; alloc_req = 1'b0; commit_alloc = 1'b0;
    free_req = 1'b0; free_reg = 6'd0; flush = 1'b0;
    test_reset();
    test_drain();
    test_free_no_bypass();
    test_flush();
    test_back_to_back();
    test_errors();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
